// File: rtl/shift_arbiter_ctrl.sv
// Round-robin arbiter sharing one external 32-bit barrel shifter between two requesters;
// rotates take two shifter passes OR'd together, results return with the requester id.
module shift_arbiter_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_amt,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_amt,
  input  logic [1:0]  req1_op,
  output logic [31:0] sh_in,
  output logic [4:0]  sh_amt,
  output logic        sh_left,
  input  logic [31:0] sh_out,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [31:0] resp_data
);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  amt_q, amt_d;
  logic [1:0]  op_q, op_d;
  logic        id_q, id_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] sh_in_q, sh_in_d;
  logic [4:0]  sh_amt_q, sh_amt_d;
  logic        sh_left_q, sh_left_d;
  logic        gnt0, gnt1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      data_q    <= '0;
      amt_q     <= '0;
      op_q      <= '0;
      id_q      <= 1'b0;
      acc_q     <= '0;
      sh_in_q   <= '0;
      sh_amt_q  <= '0;
      sh_left_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      data_q    <= data_d;
      amt_q     <= amt_d;
      op_q      <= op_d;
      id_q      <= id_d;
      acc_q     <= acc_d;
      sh_in_q   <= sh_in_d;
      sh_amt_q  <= sh_amt_d;
      sh_left_q <= sh_left_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    data_d     = data_q;
    amt_d      = amt_q;
    op_d       = op_q;
    id_d       = id_q;
    acc_d      = acc_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    sh_in      = sh_in_q;
    sh_amt     = sh_amt_q;
    sh_left    = sh_left_q;
    resp_valid = 1'b0;
    resp_id    = 1'b0;
    resp_data  = '0;

    case (state_q)
      IDLE: begin
        // Contention goes to the pointer; the pointer always moves to the loser.
        gnt0       = req0_valid && (!req1_valid || !ptr_q);
        gnt1       = req1_valid && !gnt0;
        req0_ready = gnt0 && !reset;
        req1_ready = gnt1 && !reset;
        if (gnt0 || gnt1) begin
          data_d  = gnt1 ? req1_data : req0_data;
          amt_d   = gnt1 ? req1_amt  : req0_amt;
          op_d    = gnt1 ? req1_op   : req0_op;
          id_d    = gnt1;
          ptr_d   = !gnt1;
          state_d = PASS1;
        end
      end
      PASS1: begin
        sh_in   = data_q;
        sh_amt  = amt_q;
        sh_left = !op_q[0];
        acc_d   = sh_out;
        state_d = (op_q[1] && amt_q != 5'd0) ? PASS2 : DONE;
      end
      PASS2: begin
        // Opposite-direction pass by (32 - amt) supplies the wrapped-around bits.
        sh_in   = data_q;
        sh_amt  = 5'd0 - amt_q;
        sh_left = op_q[0];
        acc_d   = acc_q | sh_out;
        state_d = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_data  = acc_q;
        resp_id    = id_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    sh_in_d   = sh_in;
    sh_amt_d  = sh_amt;
    sh_left_d = sh_left;
  end

endmodule
